// File: rtl/debug_terminal_monitor.sv
// Debug terminal monitor: snapshots watched words each frame and streams them as hex
// text cells to a character terminal, with a PC breakpoint and halt/resume control.
module debug_terminal_monitor #(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned COLUMNS      = 80,
  parameter int unsigned ROWS         = 30
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] channel_data,
  input  logic [31:0]                        cpu_pc,
  input  logic [31:0]                        breakpoint_addr,
  input  logic                               breakpoint_enable,
  input  logic                               resume,
  output logic                               cpu_halt,
  output logic [11:0]                        terminal_addr,
  output logic [7:0]                         terminal_data,
  output logic                               terminal_write,
  input  logic                               terminal_ready,
  output logic [15:0]                        frame_count
);

  localparam int unsigned D          = DATA_WIDTH / 4;
  localparam logic [4:0]  LAST_COL   = 5'(D + 4);
  localparam logic [4:0]  STATUS_ROW = 5'(NUM_CHANNELS);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || DATA_WIDTH < 4 || DATA_WIDTH > 64 ||
      DATA_WIDTH % 4 != 0 || COLUMNS < 5 + D || ROWS < NUM_CHANNELS + 1 ||
      COLUMNS * ROWS > 4096) begin : g_bad_params
    $error("debug_terminal_monitor: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SNAP, EMIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   snap [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] changed;
  logic                    stat_halt;
  logic [15:0]             stat_frame;
  logic [4:0]              cur_row, cur_col, nxt_row, nxt_col;
  logic                    nxt_last;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   sel_word;
  logic                    sel_chg;
  logic [3:0]              nib;
  logic [7:0]              cell_char;
  logic                    bp_armed;
  logic                    bp_match;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign accept   = terminal_write & terminal_ready;
  assign bp_match = breakpoint_enable & bp_armed & (cpu_pc == breakpoint_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = SNAP;
      SNAP: state_nxt = EMIT;
      EMIT: if (accept && nxt_last) state_nxt = DONE;
      DONE: state_nxt = SNAP;
      default: state_nxt = IDLE;
    endcase
  end

  // Cell pointer for the cell to be presented next; SNAP always restarts at row 0 col 0.
  always_comb begin
    nxt_row  = cur_row;
    nxt_col  = cur_col;
    nxt_last = 1'b0;
    if (state == SNAP) begin
      nxt_row = '0;
      nxt_col = '0;
    end else if (cur_row == STATUS_ROW) begin
      if (cur_col == 5'd8) nxt_last = 1'b1;
      else                 nxt_col  = cur_col + 5'd1;
    end else if (cur_col == LAST_COL) begin
      nxt_row = cur_row + 5'd1;
      nxt_col = '0;
    end else begin
      nxt_col = cur_col + 5'd1;
    end
  end

  always_comb begin
    sel_word = '0;
    sel_chg  = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (nxt_row == 5'(i)) begin
        sel_word = snap[i];
        sel_chg  = changed[i];
      end
    end
    nib = '0;
    for (int unsigned j = 0; j < D; j++) begin
      if (nxt_col == 5'(3 + j)) nib = sel_word[DATA_WIDTH-1-4*j -: 4];
    end
    cell_char = 8'h20;
    if (nxt_row == STATUS_ROW) begin
      case (nxt_col)
        5'd0:    cell_char = stat_halt ? "H" : "R";
        5'd1:    cell_char = stat_halt ? "A" : "U";
        5'd2:    cell_char = stat_halt ? "L" : "N";
        5'd3:    cell_char = stat_halt ? "T" : " ";
        5'd5:    cell_char = hex_char(stat_frame[15:12]);
        5'd6:    cell_char = hex_char(stat_frame[11:8]);
        5'd7:    cell_char = hex_char(stat_frame[7:4]);
        5'd8:    cell_char = hex_char(stat_frame[3:0]);
        default: cell_char = 8'h20;
      endcase
    end else if (nxt_col == 5'd0) begin
      cell_char = hex_char({3'b000, nxt_row[4]});
    end else if (nxt_col == 5'd1) begin
      cell_char = hex_char(nxt_row[3:0]);
    end else if (nxt_col == 5'd2) begin
      cell_char = ":";
    end else if (nxt_col == LAST_COL) begin
      cell_char = sel_chg ? "*" : " ";
    end else if (nxt_col == LAST_COL - 5'd1) begin
      cell_char = " ";
    end else begin
      cell_char = hex_char(nib);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) snap[i] <= '0;
      changed        <= '0;
      stat_halt      <= 1'b0;
      stat_frame     <= '0;
      cur_row        <= '0;
      cur_col        <= '0;
      terminal_addr  <= '0;
      terminal_data  <= '0;
      terminal_write <= 1'b0;
      frame_count    <= '0;
    end else begin
      case (state)
        SNAP: begin
          if (!cpu_halt) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
              snap[i]    <= channel_data[DATA_WIDTH*i +: DATA_WIDTH];
              changed[i] <= (channel_data[DATA_WIDTH*i +: DATA_WIDTH] != snap[i]);
            end
          end
          stat_halt      <= cpu_halt;
          stat_frame     <= frame_count;
          cur_row        <= nxt_row;
          cur_col        <= nxt_col;
          terminal_addr  <= 12'(nxt_row) * 12'(COLUMNS) + 12'(nxt_col);
          terminal_data  <= cell_char;
          terminal_write <= 1'b1;
        end
        EMIT: begin
          if (accept) begin
            if (nxt_last) begin
              terminal_write <= 1'b0;
              frame_count    <= frame_count + 16'd1;
            end else begin
              cur_row       <= nxt_row;
              cur_col       <= nxt_col;
              terminal_addr <= 12'(nxt_row) * 12'(COLUMNS) + 12'(nxt_col);
              terminal_data <= cell_char;
            end
          end
        end
        default: terminal_write <= 1'b0;
      endcase
    end
  end

  // Disarming on a match keeps a resumed CPU from re-halting until the PC moves away.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_halt <= 1'b0;
      bp_armed <= 1'b1;
    end else begin
      if (resume)        cpu_halt <= 1'b0;
      else if (bp_match) cpu_halt <= 1'b1;
      if (!breakpoint_enable || cpu_pc != breakpoint_addr) bp_armed <= 1'b1;
      else if (bp_match)                                   bp_armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_terminal_monitor.sv
// Directed bench for debug_terminal_monitor: default instance plus a 2x16-bit instance.
module tb_debug_terminal_monitor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n;
  logic [255:0] channel_data;
  logic [31:0]  cpu_pc, breakpoint_addr;
  logic         breakpoint_enable, resume, cpu_halt;
  logic [11:0]  terminal_addr;
  logic [7:0]   terminal_data;
  logic         terminal_write, terminal_ready;
  logic [15:0]  frame_count;

  logic         reset_n_2;
  logic [31:0]  channel_data_2;
  logic [31:0]  cpu_pc_2, breakpoint_addr_2;
  logic         breakpoint_enable_2, resume_2, cpu_halt_2;
  logic [11:0]  terminal_addr_2;
  logic [7:0]   terminal_data_2;
  logic         terminal_write_2, terminal_ready_2;
  logic [15:0]  frame_count_2;

  debug_terminal_monitor dut (
    .clock(clock), .reset_n(reset_n), .channel_data(channel_data),
    .cpu_pc(cpu_pc), .breakpoint_addr(breakpoint_addr),
    .breakpoint_enable(breakpoint_enable), .resume(resume), .cpu_halt(cpu_halt),
    .terminal_addr(terminal_addr), .terminal_data(terminal_data),
    .terminal_write(terminal_write), .terminal_ready(terminal_ready),
    .frame_count(frame_count)
  );

  debug_terminal_monitor #(.NUM_CHANNELS(2), .DATA_WIDTH(16)) dut2 (
    .clock(clock), .reset_n(reset_n_2), .channel_data(channel_data_2),
    .cpu_pc(cpu_pc_2), .breakpoint_addr(breakpoint_addr_2),
    .breakpoint_enable(breakpoint_enable_2), .resume(resume_2), .cpu_halt(cpu_halt_2),
    .terminal_addr(terminal_addr_2), .terminal_data(terminal_data_2),
    .terminal_write(terminal_write_2), .terminal_ready(terminal_ready_2),
    .frame_count(frame_count_2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [103:0] got, input logic [103:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  logic [7:0] mem1 [4096];
  logic [7:0] mem2 [4096];

  function automatic logic [7:0] hexc(input int unsigned n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [31:0] hex4(input logic [15:0] v);
    return {hexc(v[15:12]), hexc(v[11:8]), hexc(v[7:4]), hexc(v[3:0])};
  endfunction

  function automatic int unsigned exp_addr1(input int unsigned e);
    return (e < 104) ? (e / 13) * 80 + e % 13 : 640 + e - 104;
  endfunction

  function automatic int unsigned exp_addr2(input int unsigned e);
    return (e < 18) ? (e / 9) * 80 + e % 9 : 160 + e - 18;
  endfunction

  function automatic logic [103:0] grab(input bit second, input int unsigned base,
                                        input int unsigned n);
    logic [103:0] r = '0;
    for (int unsigned i = 0; i < n; i++)
      r = {r[95:0], second ? mem2[base + i] : mem1[base + i]};
    return r;
  endfunction

  // Cell order, shadow memory and stall stability for the default instance.
  initial begin
    int unsigned e1 = 0;
    logic stall = 1'b0;
    logic [11:0] held_a = '0;
    logic [7:0] held_d = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        e1 = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_write", terminal_write, 1);
          check("stall_addr", terminal_addr, held_a);
          check("stall_data", terminal_data, held_d);
        end
        stall  = terminal_write && !terminal_ready;
        held_a = terminal_addr;
        held_d = terminal_data;
        if (terminal_write && terminal_ready) begin
          check("order1", terminal_addr, exp_addr1(e1));
          mem1[terminal_addr] = terminal_data;
          e1 = (e1 == 112) ? 0 : e1 + 1;
        end
      end
    end
  end

  int unsigned acc2 = 0;
  initial begin
    int unsigned e2 = 0;
    forever begin
      @(negedge clock);
      if (!reset_n_2) begin
        e2 = 0;
      end else if (terminal_write_2 && terminal_ready_2) begin
        check("order2", terminal_addr_2, exp_addr2(e2));
        mem2[terminal_addr_2] = terminal_data_2;
        e2 = (e2 == 26) ? 0 : e2 + 1;
        acc2++;
      end
    end
  end

  task automatic wait_fc1(input logic [15:0] target, input string tag, output int n);
    n = 0;
    while (frame_count !== target && n < 3000) begin
      @(posedge clock); n++; @(negedge clock);
    end
    check(tag, frame_count, target);
  endtask

  task automatic wait_fc2(input logic [15:0] target, input string tag, output int n);
    n = 0;
    while (frame_count_2 !== target && n < 3000) begin
      @(posedge clock); n++; @(negedge clock);
    end
    check(tag, frame_count_2, target);
  endtask

  initial begin
    int n, k;
    int unsigned a0;
    logic [15:0] f, g;

    reset_n = 1'b0; reset_n_2 = 1'b0;
    channel_data = '0; cpu_pc = '0; breakpoint_addr = '0;
    breakpoint_enable = 1'b0; resume = 1'b0; terminal_ready = 1'b1;
    channel_data_2 = '0; cpu_pc_2 = '0; breakpoint_addr_2 = '0;
    breakpoint_enable_2 = 1'b0; resume_2 = 1'b0; terminal_ready_2 = 1'b1;

    #7;
    check("rst_write", terminal_write, 0);
    check("rst_addr", terminal_addr, 0);
    check("rst_data", terminal_data, 0);
    check("rst_halt", cpu_halt, 0);
    check("rst_fc", frame_count, 0);
    check("rst_write2", terminal_write_2, 0);
    #5;
    reset_n = 1'b1; reset_n_2 = 1'b1;

    n = 0;
    while (frame_count !== 16'd1 && n < 3000) begin
      @(posedge clock); n++; @(negedge clock);
      if (n == 1) check("snap_no_write", terminal_write, 0);
      if (n == 2) begin
        check("first_write", terminal_write, 1);
        check("first_addr", terminal_addr, 0);
        check("first_data", terminal_data, 8'h30);
      end
    end
    check("frame1_cycles", n, 115);
    check("row0_f1", grab(0, 0, 13), "00:00000000  ");
    check("status_f1", grab(0, 640, 9), "RUN  0000");
    for (int i = 0; i < 8; i++) check("no_star_f1", mem1[i*80 + 12], 8'h20);

    channel_data[3*32 +: 32] = 32'hDEADBEEF;
    wait_fc1(16'd2, "fc_f2", n);
    check("frame_period", n, 115);
    check("row3_changed", grab(0, 240, 13), "03:DEADBEEF *");
    check("row2_mark", mem1[172], 8'h20);
    check("status_f2", grab(0, 640, 9), "RUN  0001");

    wait_fc1(16'd3, "fc_f3", n);
    check("row3_steady_mark", mem1[252], 8'h20);

    k = 0;
    repeat (20) begin @(posedge clock); k++; end
    #1 terminal_ready = 1'b1;
    @(posedge clock); k++; #1 terminal_ready = 1'b0;
    @(posedge clock); k++; #1 terminal_ready = 1'b0;
    @(posedge clock); k++; #1 terminal_ready = 1'b1;
    wait_fc1(16'd4, "fc_f4", n);
    check("stall_period", k + n, 117);
    check("row3_after_stall", grab(0, 240, 13), "03:DEADBEEF  ");
    check("status_f4", grab(0, 640, 9), "RUN  0003");

    @(posedge clock); #1;
    breakpoint_addr = 32'h100; breakpoint_enable = 1'b1; cpu_pc = 32'h0FC;
    @(posedge clock); #1 cpu_pc = 32'h100;
    @(negedge clock); check("bp_not_yet", cpu_halt, 0);
    @(negedge clock); check("bp_halt", cpu_halt, 1);
    channel_data[3*32 +: 32] = 32'h12345678;
    channel_data[0 +: 32]    = 32'h00000001;
    f = frame_count;
    wait_fc1(f + 16'd2, "fc_halted", n);
    check("halt_row3_frozen", grab(0, 240, 13), "03:DEADBEEF  ");
    check("halt_row0_frozen", grab(0, 0, 13), "00:00000000  ");
    check("halt_text", grab(0, 640, 4), "HALT");
    check("halt_fc_digits", grab(0, 645, 4), hex4(f + 16'd1));
    check("halt_held", cpu_halt, 1);

    @(posedge clock); #1 resume = 1'b1;
    @(posedge clock); #1 resume = 1'b0;
    @(negedge clock); check("resume_clears", cpu_halt, 0);
    repeat (5) @(negedge clock);
    check("no_rehalt_same_pc", cpu_halt, 0);

    @(posedge clock); #1 cpu_pc = 32'h104;
    @(posedge clock); #1 cpu_pc = 32'h100;
    @(negedge clock); check("rehalt_not_yet", cpu_halt, 0);
    @(negedge clock); check("rehalt", cpu_halt, 1);

    @(posedge clock); #1 cpu_pc = 32'h104; resume = 1'b1;
    @(posedge clock); #1 cpu_pc = 32'h100; resume = 1'b1;
    @(posedge clock); #1 resume = 1'b0;
    @(negedge clock); check("resume_beats_match", cpu_halt, 0);
    repeat (3) @(negedge clock);
    check("resume_beats_match_hold", cpu_halt, 0);
    breakpoint_enable = 1'b0;

    f = frame_count;
    wait_fc1(f + 16'd2, "fc_running", n);
    check("run_row3_updated", grab(0, 240, 11), "03:12345678");
    check("run_text", grab(0, 640, 4), "RUN ");

    g = frame_count_2;
    wait_fc2(g + 16'd1, "fc2_a", n);
    a0 = acc2;
    wait_fc2(g + 16'd2, "fc2_b", n);
    check("small_period", n, 29);
    check("small_cells", acc2 - a0, 27);
    channel_data_2 = {16'hA5C3, 16'h0001};
    wait_fc2(g + 16'd3, "fc2_c", n);
    check("small_row0", grab(1, 0, 9), "00:0001 *");
    check("small_row1", grab(1, 80, 9), "01:A5C3 *");
    check("small_status_text", grab(1, 160, 4), "RUN ");
    check("small_status_fc", grab(1, 165, 4), hex4(g + 16'd2));

    k = 0;
    while (!(terminal_write_2 && terminal_addr_2 == 12'd5) && k < 200) begin
      @(negedge clock); k++;
    end
    check("mid_frame_seen", terminal_addr_2, 5);
    @(posedge clock); #2 reset_n_2 = 1'b0;
    #1;
    check("midrst_write", terminal_write_2, 0);
    check("midrst_addr", terminal_addr_2, 0);
    check("midrst_fc", frame_count_2, 0);
    @(negedge clock); #1 reset_n_2 = 1'b1;
    wait_fc2(16'd1, "fc2_after_rst", n);
    check("restart_period", n, 29);
    check("restart_row0", grab(1, 0, 9), "00:0001 *");
    check("restart_status", grab(1, 160, 9), "RUN  0000");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
